// File: rtl/fifo_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// fifo_rr_arbiter_if : leaf-FIFO read side and downstream valid/ready bundle
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_rr_arbiter_if #(
  parameter int NUM_FIFOS  = 4,
  parameter int DATA_WIDTH = 36
);
  localparam int SRC_W = $clog2(NUM_FIFOS);

  logic [NUM_FIFOS-1:0]            empty_i;
  logic [NUM_FIFOS*DATA_WIDTH-1:0] data_i;
  logic [NUM_FIFOS-1:0]            rden_o;
  logic [DATA_WIDTH-1:0]           data_o;
  logic [SRC_W-1:0]                src_o;
  logic                            valid_o;
  logic                            ready_i;

  modport master (
    input  empty_i, data_i, ready_i,
    output rden_o, data_o, src_o, valid_o
  );

  modport slave (
    output empty_i, data_i, ready_i,
    input  rden_o, data_o, src_o, valid_o
  );
endinterface
`default_nettype wire

// File: rtl/fifo_rr_arbiter.sv
`default_nettype none
// ============================================================================
// fifo_rr_arbiter : round-robin reader of a bank of leaf FIFOs, forwarding one
//                   tagged word at a time through a valid/ready register.
//                   Optional statistics ports under FIFO_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rr_arbiter #(
  parameter  int NUM_FIFOS  = 4,
  parameter  int DATA_WIDTH = 36,
  localparam int SRC_W      = $clog2(NUM_FIFOS)
) (
  input  wire logic         clk,
  input  wire logic         reset,
  fifo_rr_arbiter_if.master bus
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [31:0]       word_cnt_o,
  output logic [SRC_W-1:0]  last_grant_o
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    CAPT = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]      grant_q, grant_d;
  logic [SRC_W-1:0]      src_q, src_d;
  logic [NUM_FIFOS-1:0]  rden_q, rden_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
`ifdef FIFO_ARB_STATS_EN
  logic [31:0]           word_cnt_q, word_cnt_d;
  logic [SRC_W-1:0]      last_grant_q, last_grant_d;
`endif

  logic [DATA_WIDTH-1:0] words [NUM_FIFOS];
  logic [SRC_W-1:0]      pick;

  for (genvar k = 0; k < NUM_FIFOS; k++) begin : g_words
    assign words[k] = bus.data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan offsets from the far end down so the nearest non-empty FIFO wins.
  always_comb begin : search
    int               idx;
    logic [SRC_W-1:0] idx_s;
    pick  = rr_ptr_q;
    idx   = 0;
    idx_s = '0;
    for (int i = NUM_FIFOS - 1; i >= 0; i--) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_FIFOS) idx = idx - NUM_FIFOS;
      idx_s = SRC_W'(idx);
      if (!bus.empty_i[idx_s]) pick = idx_s;
    end
  end

  always_comb begin : next_state
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    src_d    = src_q;
    rden_d   = rden_q;
    data_d   = data_q;
    valid_d  = valid_q;
`ifdef FIFO_ARB_STATS_EN
    word_cnt_d   = word_cnt_q;
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (!(&bus.empty_i)) begin
          grant_d       = pick;
          rden_d        = '0;
          rden_d[pick]  = 1'b1;
          state_d       = READ;
`ifdef FIFO_ARB_STATS_EN
          last_grant_d  = pick;
`endif
        end
      end
      READ: begin
        rden_d  = '0;
        state_d = CAPT;
      end
      CAPT: begin
        data_d  = words[grant_q];
        src_d   = grant_q;
        valid_d = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (bus.ready_i) begin
          valid_d  = 1'b0;
          rr_ptr_d = (grant_q == SRC_W'(NUM_FIFOS - 1)) ? '0 : grant_q + 1'b1;
          state_d  = IDLE;
`ifdef FIFO_ARB_STATS_EN
          word_cnt_d = word_cnt_q + 32'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      src_q    <= '0;
      rden_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
`ifdef FIFO_ARB_STATS_EN
      word_cnt_q   <= '0;
      last_grant_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      src_q    <= src_d;
      rden_q   <= rden_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
`ifdef FIFO_ARB_STATS_EN
      word_cnt_q   <= word_cnt_d;
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign bus.rden_o  = rden_q;
  assign bus.data_o  = data_q;
  assign bus.src_o   = src_q;
  assign bus.valid_o = valid_q;
`ifdef FIFO_ARB_STATS_EN
  assign word_cnt_o   = word_cnt_q;
  assign last_grant_o = last_grant_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_fifo_rr_arbiter : scoreboard bench for fifo_rr_arbiter with queue-based
//                      leaf FIFO models. Honours FIFO_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rr_arbiter;
  localparam int NF = 4;
  localparam int DW = 36;
  localparam int SW = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fifo_rr_arbiter_if #(.NUM_FIFOS(NF), .DATA_WIDTH(DW)) bus ();

`ifdef FIFO_ARB_STATS_EN
  logic [31:0]   word_cnt;
  logic [SW-1:0] last_grant;
`endif

  fifo_rr_arbiter #(.NUM_FIFOS(NF), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FIFO_ARB_STATS_EN
    ,
    .word_cnt_o   (word_cnt),
    .last_grant_o (last_grant)
`endif
  );

  logic [NF-1:0]    tb_empty = '1;
  logic [NF*DW-1:0] tb_data  = '0;
  logic             tb_ready = 1'b1;
  assign bus.empty_i = tb_empty;
  assign bus.data_i  = tb_data;
  assign bus.ready_i = tb_ready;

  int total = 0;
  int bad   = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Leaf FIFO models: a pop during the rden cycle presents the word for CAPT.
  logic [DW-1:0] fq [NF][$];
  int rden_hi [NF] = '{default: 0};
  int rden_tot = 0;
  int rden_cyc = 0;

  always @(negedge clk) begin
    if (bus.rden_o != '0) check("rden_onehot", 64'($onehot(bus.rden_o)), 1);
    for (int k = 0; k < NF; k++) begin
      if (bus.rden_o[k]) begin
        rden_hi[k]++;
        rden_tot++;
        rden_cyc = cyc;
        check("rden_nonempty", 64'(fq[k].size() != 0), 1);
        if (fq[k].size() != 0) tb_data[k*DW +: DW] = fq[k].pop_front();
      end
      tb_empty[k] = (fq[k].size() == 0);
    end
  end

  typedef struct packed {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
  } exp_t;
  exp_t exp_q [$];
  logic valid_prev = 1'b0;
  int   hs = 0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      valid_prev = 1'b0;
    end else begin
      if (bus.valid_o && !valid_prev) check("latency", 64'(cyc - rden_cyc), 2);
      if (bus.valid_o && bus.ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(exp_q.size()), 1);
        end else begin
          e = exp_q.pop_front();
          check("data", 64'(bus.data_o), 64'(e.d));
          check("src", 64'(bus.src_o), 64'(e.s));
          hs++;
        end
      end
      valid_prev = bus.valid_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int k, logic [DW-1:0] w);
    fq[k].push_back(w);
  endtask

  task automatic expect_word(logic [DW-1:0] d, int s);
    exp_t e;
    e.d = d;
    e.s = SW'(s);
    exp_q.push_back(e);
  endtask

  task automatic drain(string name, int budget);
    int n = 0;
    while ((exp_q.size() != 0 || bus.valid_o || bus.rden_o != '0) && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(n < budget), 1);
  endtask

  initial begin
    int            r2, t2, h3, n;
    logic [DW-1:0] w;

    tick();
    tick();
    reset = 1'b0;
    check("rst_data", 64'(bus.data_o), 0);
    check("rst_src", 64'(bus.src_o), 0);
`ifdef FIFO_ARB_STATS_EN
    check("rst_word_cnt", 64'(word_cnt), 0);
    check("rst_last_grant", 64'(last_grant), 0);
`endif
    repeat (20) begin
      tick();
      check("idle_quiet", 64'({bus.rden_o, bus.valid_o}), 0);
    end

    // Single word from FIFO 2.
    r2 = rden_hi[2];
    t2 = rden_tot;
    push(2, 36'h9_1234_5678);
    expect_word(36'h9_1234_5678, 2);
    drain("t2_drain", 50);
    check("t2_rden2_once", 64'(rden_hi[2] - r2), 1);
    check("t2_rden_total", 64'(rden_tot - t2), 1);

    // Full bank: fairness and per-FIFO ordering, starting from rr_ptr=0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    h3 = hs;
    for (int j = 0; j < 3; j++)
      for (int k = 0; k < NF; k++)
        push(k, DW'(36'hA_0000_0000 + k * 256 + j));
    for (int j = 0; j < 3; j++)
      for (int k = 0; k < NF; k++)
        expect_word(DW'(36'hA_0000_0000 + k * 256 + j), k);
    drain("t3_drain", 200);
    check("t3_handshakes", 64'(hs - h3), 12);
`ifdef FIFO_ARB_STATS_EN
    check("t3_word_cnt", 64'(word_cnt), 64'(hs - h3));
`endif

    // Back-pressure in OUT.
    tb_ready = 1'b0;
    push(0, 36'h0_DEAD_BEEF);
    expect_word(36'h0_DEAD_BEEF, 0);
    n = 0;
    while (!bus.valid_o && n < 20) begin
      tick();
      n++;
    end
    check("t4_valid_seen", 64'(bus.valid_o), 1);
    repeat (10) begin
      tick();
      check("t4_hold_valid", 64'(bus.valid_o), 1);
      check("t4_hold_data", 64'(bus.data_o), 36'h0_DEAD_BEEF);
      check("t4_hold_src", 64'(bus.src_o), 0);
      check("t4_no_rden", 64'(bus.rden_o), 0);
    end
    tb_ready = 1'b1;
    drain("t4_drain", 20);

    // Skip empty FIFOs: after FIFO 2 rr_ptr=3, with 3/0 empty FIFO 1 wins.
    push(2, 36'h2_0000_0002);
    expect_word(36'h2_0000_0002, 2);
    drain("t5a_drain", 20);
    push(1, 36'h1_0000_0001);
    expect_word(36'h1_0000_0001, 1);
    drain("t5b_drain", 20);
`ifdef FIFO_ARB_STATS_EN
    check("t5_last_grant", 64'(last_grant), 1);
`endif
    push(1, 36'h1_0000_0011);
    push(2, 36'h2_0000_0022);
    push(3, 36'h3_0000_0033);
    expect_word(36'h2_0000_0022, 2);
    expect_word(36'h3_0000_0033, 3);
    expect_word(36'h1_0000_0011, 1);
    drain("t5c_drain", 50);

    // Reset during CAPT discards the popped word and restarts at FIFO 0.
    push(3, 36'h3_3333_3333);
    n = 0;
    while (bus.rden_o == '0 && n < 20) begin
      tick();
      n++;
    end
    check("t6_rden_seen", 64'(bus.rden_o), 64'(4'b1000));
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_valid", 64'(bus.valid_o), 0);
    check("t6_rden", 64'(bus.rden_o), 0);
    check("t6_data", 64'(bus.data_o), 0);
`ifdef FIFO_ARB_STATS_EN
    check("t6_word_cnt", 64'(word_cnt), 0);
`endif
    w = 36'h0_0000_00AA;
    push(0, w);
    push(3, 36'h3_0000_00BB);
    expect_word(w, 0);
    expect_word(36'h3_0000_00BB, 3);
    drain("t6_drain", 50);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
